// File: rtl/rvb_clmul_pkg.sv
// Shared types for the sequential carry-less multiplier: op codes, FSM
// states and a bit-serial reference product used when checking results.
// Optional build macro: RVB_CLMUL_EARLY_EXIT_EN (see rvb_clmul_seq.sv).
package rvb_clmul_pkg;

    typedef enum logic [1:0] {
        OP_CLMUL  = 2'b00,
        OP_CLMULH = 2'b01,
        OP_CLMULR = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Full carry-less product of two operands up to 64 bits wide.
    function automatic logic [127:0] clmul_ref(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) r = r ^ ({64'b0, a} << i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rvb_clmul_seq_if.sv
// Request/response bus of the carry-less multiplier.
// master = issue/writeback side, slave = the multiplier.
interface rvb_clmul_seq_if #(
    parameter int XLEN = 32
);
    logic            din_valid;
    logic            din_ready;
    logic [1:0]      din_op;
    logic [XLEN-1:0] din_rs1;
    logic [XLEN-1:0] din_rs2;
    logic            dout_valid;
    logic            dout_ready;
    logic [XLEN-1:0] dout_rd;
    logic            busy;

    modport master (
        output din_valid, din_op, din_rs1, din_rs2, dout_ready,
        input  din_ready, dout_valid, dout_rd, busy
    );

    modport slave (
        input  din_valid, din_op, din_rs1, din_rs2, dout_ready,
        output din_ready, dout_valid, dout_rd, busy
    );
endinterface

// File: rtl/rvb_clmul_step.sv
// One BPC-bit step of the carry-less product: XOR the shifted rs1 into
// the accumulator once for every set bit of the current rs2 slice.
module rvb_clmul_step #(
    parameter int XLEN = 32,
    parameter int BPC  = 8
) (
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [2*XLEN-1:0] a_sh,
    input  logic [BPC-1:0]    b_slice,
    output logic [2*XLEN-1:0] acc_out
);

    // Partial products for this slice folded into the accumulator.
    always_comb begin
        acc_out = acc_in;
        for (int j = 0; j < BPC; j++) begin
            if (b_slice[j]) acc_out = acc_out ^ (a_sh << j);
        end
    end

endmodule

// File: rtl/rvb_clmul_seq.sv
// Multi-cycle carry-less multiplier (CLMUL / CLMULH / CLMULR), BPC bits of
// rs2 per cycle, valid/ready on both sides.
// Optional build macro: RVB_CLMUL_EARLY_EXIT_EN -- finish RUN as soon as
// the unconsumed rs2 bits are all zero (latency 1..NSTEP instead of NSTEP).
module rvb_clmul_seq
    import rvb_clmul_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 8
) (
    input  logic          clock,
    input  logic          reset,
    rvb_clmul_seq_if.slave bus
);

    localparam int NSTEP = XLEN / BPC;
    localparam int CW    = $clog2(NSTEP + 1);

    state_e            state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] a_sh;     // rs1 pre-shifted to the current slice position
    logic [XLEN-1:0]   b_rem;    // rs2 bits not yet consumed, LSB chunk first
    op_e               op_q;
    logic              dout_valid_q;
    logic [XLEN-1:0]   dout_rd_q;
    logic              busy_q;

    logic [2*XLEN-1:0] acc_nxt;
    logic              din_ready;
    logic              accept;
    logic              last_step;

    rvb_clmul_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
        .acc_in  (acc),
        .a_sh    (a_sh),
        .b_slice (b_rem[BPC-1:0]),
        .acc_out (acc_nxt)
    );

    // Ready depends on state and the consumer only, never on din_valid.
    assign din_ready = (state == IDLE) || (state == DONE && bus.dout_ready);
    assign accept    = bus.din_valid && din_ready;

    // Last step: counter exhausted, or (early exit) nothing left in rs2.
    always_comb begin
        last_step = (cnt == CW'(1));
`ifdef RVB_CLMUL_EARLY_EXIT_EN
        if ((b_rem >> BPC) == '0) last_step = 1'b1;
`endif
    end

    // Final result selection from the full product.
    function automatic logic [XLEN-1:0] pick(input op_e op, input logic [2*XLEN-1:0] p);
        case (op)
            OP_CLMUL:  return p[XLEN-1:0];
            OP_CLMULH: return p[XLEN +: XLEN];
            OP_CLMULR: return p[XLEN-1 +: XLEN];
            default:   return '0;
        endcase
    endfunction

    // FSM with registered outputs; an accept in IDLE or DONE reloads the datapath.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            a_sh         <= '0;
            b_rem        <= '0;
            op_q         <= OP_CLMUL;
            dout_valid_q <= 1'b0;
            dout_rd_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                RUN: begin
                    acc   <= acc_nxt;
                    a_sh  <= a_sh << BPC;
                    b_rem <= b_rem >> BPC;
                    cnt   <= cnt - CW'(1);
                    if (last_step) begin
                        state        <= DONE;
                        dout_valid_q <= 1'b1;
                        dout_rd_q    <= pick(op_q, acc_nxt);
                    end
                end
                DONE: begin
                    if (bus.dout_ready) begin
                        state        <= IDLE;
                        dout_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
            // Later assignment wins over the DONE->IDLE retire for back-to-back ops.
            if (accept) begin
                state  <= RUN;
                busy_q <= 1'b1;
                cnt    <= CW'(NSTEP);
                acc    <= '0;
                a_sh   <= {{XLEN{1'b0}}, bus.din_rs1};
                b_rem  <= bus.din_rs2;
                op_q   <= op_e'(bus.din_op);
            end
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_rd    = dout_rd_q;
    assign bus.busy       = busy_q;

endmodule
